pipe_stage_buffer: RTL and testbench
====================================

PIPE_STAGE_BUFFER -- requirements
Module: pipe_stage_buffer

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the payload width in bits carried between pipeline stages.
REQ-002 Parameter DEPTH, default 2, SHALL set the entry count; legal range is 1..8.
REQ-003 Port clk  in  1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  in  1: the reset, synchronous and active-high.
REQ-005 Port i_valid  in  1: the upstream stage presents a payload.
REQ-006 Port i_data  in  DATA_W: the upstream payload.
REQ-007 Port o_ready  out  1: the buffer accepts a payload this cycle.
REQ-008 Port i_flush  in  1: discard all held entries (branch mispredict or redirect).
REQ-009 Port o_valid  out  1: the head entry is presented downstream.
REQ-010 Port o_data  out  DATA_W: the head payload.
REQ-011 Port i_ready  in  1: the downstream stage consumes the head this cycle.
REQ-012 Port o_count  out  $clog2(DEPTH+1): the number of occupied entries.

Function
REQ-013 A push SHALL occur when i_valid & o_ready & ~i_flush.
REQ-014 A pop SHALL occur when o_valid & i_ready & ~i_flush.
REQ-015 o_ready SHALL equal (o_count < DEPTH) and SHALL NOT depend combinationally on i_ready or i_valid.
REQ-016 o_valid SHALL equal (o_count != 0) and be driven from registers only.
REQ-017 Latency: a payload pushed in cycle N SHALL appear on o_valid/o_data in cycle N+1 at the earliest; there is no same-cycle bypass.
REQ-018 Ordering SHALL be strict FIFO.
REQ-019 When o_valid = 0, o_data SHALL be all zeros.
REQ-020 A simultaneous push and pop SHALL leave o_count unchanged and advance both pointers.
REQ-021 When full, o_ready SHALL be 0; a pop in that cycle SHALL NOT enable a same-cycle push.
REQ-022 Write and read pointers SHALL wrap from DEPTH-1 to 0, including non-power-of-two DEPTH.
REQ-023 In the cycle after i_flush = 1, o_count SHALL be 0, both pointers SHALL be 0, and o_valid SHALL be 0; any concurrent push or pop is ignored.
REQ-024 A push while empty with i_ready = 1 SHALL NOT pop in the same cycle, as a consequence of REQ-016.

Reset
REQ-025 While rst = 1 at a clock edge, o_count, both pointers, o_valid and o_data SHALL be cleared to 0; rst SHALL take priority over i_flush, push and pop.
REQ-026 Storage array contents need not be reset; after reset, o_data SHALL be 0 regardless via REQ-019.
REQ-027 Reset asserted mid-operation SHALL discard all entries exactly as a flush does.

Configuration
REQ-028 With macro PIPE_STAGE_BUFFER_STATS_EN defined, the block SHALL add outputs o_stall_cycles (32 bits) and o_flush_count (16 bits).
REQ-029 o_stall_cycles SHALL count cycles with i_valid & ~o_ready.
REQ-030 o_flush_count SHALL count cycles with i_flush = 1.
REQ-031 Both counters SHALL saturate at their maximum value and clear on rst.
REQ-032 Without the macro, these ports and counters SHALL not exist and the function SHALL be otherwise identical.

Structure
REQ-033 The stage payload typedefs (pr_pass_t, act_pass_t, writeback_t) and the DEPTH limit constant SHALL live in the shared nand_cpu_pkg package, so stages instantiate the block with DATA_W = $bits(type).
REQ-034 The statistics counter SHALL be a sub-module, sat_counter, parameterised by width, and instantiated twice under the macro.
REQ-035 The block SHALL contain no other sub-modules.

Verification
REQ-036 Reset, then push 0x1234: next cycle o_valid = 1, o_data = 0x1234, o_count = 1.
REQ-037 DEPTH = 2, i_ready = 0, push 0xA, 0xB, 0xC: o_ready = 0 after two pushes; 0xC is not accepted; draining yields 0xA then 0xB.
REQ-038 DEPTH = 3, continuous push/pop of 0..20 with i_ready toggling each cycle: output sequence is 0..20 in order with no loss across pointer wrap.
REQ-039 Full buffer, i_flush = 1 together with i_valid = 1 (0x55): next cycle o_count = 0, o_valid = 0, o_data = 0; 0x55 is never output.
REQ-040 Mid-stream rst = 1 with o_count = 2: next cycle all outputs are 0; with stats enabled, both counters read 0.
REQ-041 With PIPE_STAGE_BUFFER_STATS_EN, hold full with i_valid = 1 for 5 cycles and flush twice: o_stall_cycles = 5, o_flush_count = 2.

Source files
------------

// File: rtl/nand_cpu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : nand_cpu_pkg
// Description : Shared definitions for the pipeline: the payload types carried
//               between stages and the depth limit of the inter-stage buffer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package nand_cpu_pkg;

    // Largest legal entry count for pipe_stage_buffer
    localparam int c_PSB_DEPTH_MAX = 8;

    // Fetch/decode -> register read
    typedef struct packed {
        logic [7:0] pc;
        logic [7:0] instr;
    } pr_pass_t;

    // Register read -> execute
    typedef struct packed {
        logic [7:0] pc;
        logic [3:0] opcode;
        logic [7:0] op_a;
        logic [7:0] op_b;
        logic [2:0] rd;
    } act_pass_t;

    // Execute -> writeback
    typedef struct packed {
        logic [7:0] result;
        logic [2:0] rd;
        logic       we;
    } writeback_t;

endpackage : nand_cpu_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sat_counter
// Description : Event counter that sticks at its all-ones maximum and clears
//               on synchronous reset.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count qualifying cycles, holding once the maximum is reached
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pipe_stage_buffer
// Description : Small valid/ready FIFO placed between pipeline stages, with
//               flush for redirects. No same-cycle bypass; outputs come from
//               registers only.
//               Optional macro PIPE_STAGE_BUFFER_STATS_EN adds stall and
//               flush statistics counters.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pipe_stage_buffer
    import nand_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_valid,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_ready,
    input  logic                       i_flush,
    output logic                       o_valid,
    output logic [DATA_W-1:0]          o_data,
    input  logic                       i_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_count
`ifdef PIPE_STAGE_BUFFER_STATS_EN
    ,
    output logic [31:0]                o_stall_cycles,
    output logic [15:0]                o_flush_count
`endif
);

    // A single-entry buffer still needs a one-bit pointer
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] c_DEPTH    = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;

    logic              w_push;
    logic              w_pop;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;

    // Handshake flags derive only from the occupancy register
    assign o_ready = (r_count < c_DEPTH);
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    // Flush suppresses both transfers in its cycle
    assign w_push = i_valid && o_ready && !i_flush;
    assign w_pop  = o_valid && i_ready && !i_flush;

    // Explicit wrap so non-power-of-two depths cycle correctly
    assign w_wr_ptr_nxt = (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);

    // Head payload is forced to zero whenever nothing is presented
    always_comb begin
        o_data = '0;
        if (o_valid) begin
            o_data = r_mem[r_rd_ptr];
        end
    end

    // Pointer and occupancy update; reset outranks flush, flush outranks traffic
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: unread entries are masked by o_valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic w_stall;
    assign w_stall = i_valid && !o_ready;

    sat_counter #(
        .WIDTH   (32)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_stall),
        .o_count (o_stall_cycles)
    );

    sat_counter #(
        .WIDTH   (16)
    ) u_flush_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (i_flush),
        .o_count (o_flush_count)
    );
`endif

endmodule : pipe_stage_buffer
`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_pipe_stage_buffer
// Description : Directed self-checking bench for pipe_stage_buffer with a
//               DEPTH=2 and a DEPTH=3 instance.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // DEPTH = 2 instance
    logic        i_valid2 = 1'b0;
    logic [15:0] i_data2  = '0;
    logic        i_flush2 = 1'b0;
    logic        i_ready2 = 1'b0;
    logic        o_ready2;
    logic        o_valid2;
    logic [15:0] o_data2;
    logic [1:0]  o_count2;

    // DEPTH = 3 instance
    logic        i_valid3 = 1'b0;
    logic [15:0] i_data3  = '0;
    logic        i_flush3 = 1'b0;
    logic        i_ready3 = 1'b0;
    logic        o_ready3;
    logic        o_valid3;
    logic [15:0] o_data3;
    logic [1:0]  o_count3;

`ifdef PIPE_STAGE_BUFFER_STATS_EN
    logic [31:0] o_stall2, o_stall3;
    logic [15:0] o_fcnt2, o_fcnt3;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buffer #(.DATA_W(16), .DEPTH(2)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid2),
        .i_data  (i_data2),
        .o_ready (o_ready2),
        .i_flush (i_flush2),
        .o_valid (o_valid2),
        .o_data  (o_data2),
        .i_ready (i_ready2),
        .o_count (o_count2)
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        ,
        .o_stall_cycles (o_stall2),
        .o_flush_count  (o_fcnt2)
`endif
    );

    pipe_stage_buffer #(.DATA_W(16), .DEPTH(3)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid3),
        .i_data  (i_data3),
        .o_ready (o_ready3),
        .i_flush (i_flush3),
        .o_valid (o_valid3),
        .o_data  (o_data3),
        .i_ready (i_ready3),
        .o_count (o_count3)
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        ,
        .o_stall_cycles (o_stall3),
        .o_flush_count  (o_fcnt3)
`endif
    );

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int next_push;
        int next_pop;

        // ---------------- reset ----------------
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_count", 32'(o_count2), 32'd0);
        check("rst_valid", 32'(o_valid2), 32'd0);
        check("rst_data",  32'(o_data2),  32'd0);
        check("rst_ready", 32'(o_ready2), 32'd1);
        check("rst_count3", 32'(o_count3), 32'd0);

        // ---------------- push 0x1234 while empty with i_ready=1 ----------------
        i_valid2 = 1'b1; i_data2 = 16'h1234; i_ready2 = 1'b1;
        check("no_bypass_valid", 32'(o_valid2), 32'd0);
        step();
        i_valid2 = 1'b0; i_ready2 = 1'b0;
        check("push1_valid", 32'(o_valid2), 32'd1);
        check("push1_data",  32'(o_data2),  32'h1234);
        check("push1_count", 32'(o_count2), 32'd1);
        i_ready2 = 1'b1;
        step();
        i_ready2 = 1'b0;
        check("pop1_count", 32'(o_count2), 32'd0);
        check("pop1_data",  32'(o_data2),  32'd0);

        // ---------------- fill DEPTH=2 with A, B; C refused ----------------
        i_valid2 = 1'b1; i_data2 = 16'h000A; step();
        i_data2 = 16'h000B; step();
        check("full_ready", 32'(o_ready2), 32'd0);
        check("full_count", 32'(o_count2), 32'd2);
        i_data2 = 16'h000C; step();
        check("refused_count", 32'(o_count2), 32'd2);
        check("head_A", 32'(o_data2), 32'hA);
        // pop while full: C still not accepted in that cycle
        i_ready2 = 1'b1; step();
        check("fullpop_count", 32'(o_count2), 32'd1);
        check("head_B", 32'(o_data2), 32'hB);
        // simultaneous push C and pop B: count unchanged
        step();
        check("pushpop_count", 32'(o_count2), 32'd1);
        check("head_C", 32'(o_data2), 32'hC);
        i_valid2 = 1'b0; step();
        check("drain_count", 32'(o_count2), 32'd0);
        check("drain_valid", 32'(o_valid2), 32'd0);
        i_ready2 = 1'b0;

        // ---------------- flush a full buffer with concurrent push ----------------
        i_valid2 = 1'b1; i_data2 = 16'h0001; step();
        i_data2 = 16'h0002; step();
        check("preflush_count", 32'(o_count2), 32'd2);
        i_flush2 = 1'b1; i_data2 = 16'h0055; step();
        i_flush2 = 1'b0; i_valid2 = 1'b0;
        check("flush_count", 32'(o_count2), 32'd0);
        check("flush_valid", 32'(o_valid2), 32'd0);
        check("flush_data",  32'(o_data2),  32'd0);
        i_ready2 = 1'b1;
        step();
        check("flush_no55_valid", 32'(o_valid2), 32'd0);
        i_ready2 = 1'b0;

        // ---------------- statistics: 5 stall cycles, 2 flushes ----------------
        rst = 1'b1; step(); rst = 1'b0;
        i_valid2 = 1'b1; i_data2 = 16'h0011; step();
        i_data2 = 16'h0022; step();
        for (int k = 0; k < 5; k++) step();
        i_valid2 = 1'b0;
        i_flush2 = 1'b1; step(); step();
        i_flush2 = 1'b0;
        check("stats_flushed_count", 32'(o_count2), 32'd0);
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        check("stall_cycles", o_stall2, 32'd5);
        check("flush_cnt",    32'(o_fcnt2), 32'd2);
`endif

        // ---------------- mid-stream reset with two entries ----------------
        i_valid2 = 1'b1; i_data2 = 16'h0033; step();
        i_data2 = 16'h0044; step();
        i_valid2 = 1'b0;
        check("prerst_count", 32'(o_count2), 32'd2);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_count", 32'(o_count2), 32'd0);
        check("midrst_valid", 32'(o_valid2), 32'd0);
        check("midrst_data",  32'(o_data2),  32'd0);
        check("midrst_ready", 32'(o_ready2), 32'd1);
`ifdef PIPE_STAGE_BUFFER_STATS_EN
        check("midrst_stall", o_stall2, 32'd0);
        check("midrst_fcnt",  32'(o_fcnt2), 32'd0);
`endif

        // ---------------- DEPTH=3 streaming 0..20 with toggling i_ready ----------------
        next_push = 0;
        next_pop  = 0;
        for (int cyc = 0; cyc < 200 && next_pop < 21; cyc++) begin
            i_valid3 = (next_push < 21);
            i_data3  = 16'(next_push);
            i_ready3 = (cyc % 2 == 0);
            if (o_valid3 && i_ready3) begin
                check("stream_data", 32'(o_data3), 32'(next_pop));
                next_pop++;
            end
            if (i_valid3 && o_ready3) next_push++;
            step();
        end
        i_valid3 = 1'b0;
        i_ready3 = 1'b0;
        check("stream_all_popped", 32'(next_pop), 32'd21);
        check("stream_end_count",  32'(o_count3), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stage_buffer
`default_nettype wire
